// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline debug/hazard controller: FSM state codes
// and the stall counter width.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_hazard.sv
// Combinational load-use and taken-branch detection for the ID/EX boundary.
module pipe_hazard (
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_mem_ren,
  input  logic       ex_wb_wen,
  input  logic [4:0] ex_wb_addr,
  input  logic       ex_branch_taken,
  output logic       load_use,
  output logic       branch_flush
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match     = id_uses_rs && (id_rs == ex_wb_addr);
    rt_match     = id_uses_rt && (id_rt == ex_wb_addr);
    load_use     = ex_mem_ren && ex_wb_wen && (ex_wb_addr != 5'd0) && (rs_match || rt_match);
    branch_flush = ex_branch_taken;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline run/halt/step controller with breakpoints and load-use stall gating.
// Breakpoint comparators are built only when PIPE_CTRL_BP_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned NUM_BP = 4,
  parameter int unsigned STEP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     debug_en,
  input  logic                     debug_step,
  input  logic [STEP_W-1:0]        step_count,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]        bp_valid,
  input  logic [ADDR_W-1:0]        if_pc,
  input  logic [4:0]               id_rs,
  input  logic [4:0]               id_rt,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic                     ex_mem_ren,
  input  logic                     ex_wb_wen,
  input  logic [4:0]               ex_wb_addr,
  input  logic                     ex_branch_taken,
  output logic                     cpu_rst,
  output logic                     if_en,
  output logic                     id_en,
  output logic                     ex_en,
  output logic                     mem_en,
  output logic                     wb_en,
  output logic                     id_flush,
  output logic                     ex_flush,
  output logic [1:0]               dbg_state,
  output logic                     dbg_halted,
  output logic [NUM_BP-1:0]        bp_hit,
  output logic [STALL_CNT_W-1:0]   stall_cnt
);

  state_t                 state_q, state_d;
  logic [STEP_W-1:0]      cnt_q, cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   step_prev_q;
  logic                   rst_q;
  logic                   step_edge;
  logic                   load_use;
  logic                   branch_flush;
  logic                   stall;
  logic                   active;
  logic                   stalled;
  logic [NUM_BP-1:0]      bp_match;
  logic                   bp_any;

  pipe_hazard u_hazard (
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .ex_mem_ren      (ex_mem_ren),
    .ex_wb_wen       (ex_wb_wen),
    .ex_wb_addr      (ex_wb_addr),
    .ex_branch_taken (ex_branch_taken),
    .load_use        (load_use),
    .branch_flush    (branch_flush)
  );

`ifdef PIPE_CTRL_BP_EN
  always_comb begin
    bp_match = '0;
    for (int unsigned i = 0; i < NUM_BP; i++) begin
      bp_match[i] = bp_valid[i] && (bp_addr[i*ADDR_W +: ADDR_W] == if_pc);
    end
  end
`else
  logic unused_bp;
  assign bp_match  = '0;
  assign unused_bp = ^{bp_addr, bp_valid, if_pc};
`endif

  // A taken branch flushes the dependent ID instruction, so the hazard is moot.
  assign stall     = load_use && !branch_flush;
  // The cycle right after reset never sees a step edge, even if debug_step was held.
  assign step_edge = debug_step && !step_prev_q && !rst_q;
  assign bp_hit    = (!rst && state_q == ST_RUN) ? bp_match : '0;
  assign bp_any    = |bp_hit;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active   = 1'b0;
    stalled  = 1'b0;
    if_en    = 1'b0;
    id_en    = 1'b0;
    ex_en    = 1'b0;
    mem_en   = 1'b0;
    wb_en    = 1'b0;
    id_flush = 1'b0;
    ex_flush = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (bp_any) begin
          state_d = ST_HALT;
        end else begin
          active = 1'b1;
          if (debug_en) state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!debug_en) begin
          state_d = ST_RUN;
        end else if (step_edge) begin
          state_d = ST_STEP;
          cnt_d   = (step_count == '0) ? STEP_W'(1) : step_count;
        end
      end
      ST_STEP: begin
        active = 1'b1;
        if (!debug_en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (!stall) begin
          if (cnt_q <= STEP_W'(1)) begin
            state_d = ST_HALT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - STEP_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_HALT;
        cnt_d   = '0;
      end
    endcase

    if (active && !rst) begin
      if_en    = !stall;
      id_en    = !stall;
      ex_en    = 1'b1;
      mem_en   = 1'b1;
      wb_en    = 1'b1;
      id_flush = branch_flush;
      ex_flush = branch_flush || stall;
      stalled  = stall;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= debug_en ? ST_HALT : ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      step_prev_q <= 1'b0;
      rst_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_prev_q <= debug_step;
      rst_q       <= 1'b0;
      if (stalled && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign cpu_rst    = rst;
  assign dbg_state  = state_q;
  assign dbg_halted = (state_q == ST_HALT);
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; breakpoint checks follow PIPE_CTRL_BP_EN.
module tb_pipe_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned NUM_BP = 4;
  localparam int unsigned STEP_W = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     debug_en;
  logic                     debug_step;
  logic [STEP_W-1:0]        step_count;
  logic [NUM_BP*ADDR_W-1:0] bp_addr;
  logic [NUM_BP-1:0]        bp_valid;
  logic [ADDR_W-1:0]        if_pc;
  logic [4:0]               id_rs, id_rt, ex_wb_addr;
  logic                     id_uses_rs, id_uses_rt, ex_mem_ren, ex_wb_wen, ex_branch_taken;
  logic                     cpu_rst, if_en, id_en, ex_en, mem_en, wb_en, id_flush, ex_flush;
  logic [1:0]               dbg_state;
  logic                     dbg_halted;
  logic [NUM_BP-1:0]        bp_hit;
  logic [15:0]              stall_cnt;
  logic [4:0]               en;
  logic [1:0]               fl;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  assign en = {if_en, id_en, ex_en, mem_en, wb_en};
  assign fl = {id_flush, ex_flush};

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(ADDR_W), .NUM_BP(NUM_BP), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .step_count(step_count), .bp_addr(bp_addr), .bp_valid(bp_valid), .if_pc(if_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_ren(ex_mem_ren), .ex_wb_wen(ex_wb_wen), .ex_wb_addr(ex_wb_addr),
    .ex_branch_taken(ex_branch_taken), .cpu_rst(cpu_rst), .if_en(if_en), .id_en(id_en),
    .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en), .id_flush(id_flush), .ex_flush(ex_flush),
    .dbg_state(dbg_state), .dbg_halted(dbg_halted), .bp_hit(bp_hit), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic hz(input logic mr, input logic wen, input logic [4:0] wa,
                    input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                    input logic urt, input logic br);
    ex_mem_ren = mr; ex_wb_wen = wen; ex_wb_addr = wa;
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt; ex_branch_taken = br;
  endtask

  initial begin
    rst = 1'b1; debug_en = 1'b0; debug_step = 1'b0; step_count = '0;
    bp_addr = '0; bp_valid = '0; if_pc = '0;
    hz(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();

    settle();
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_en", 32'(en), 32'h00);
    check("rst_flush", 32'(fl), 32'h0);
    check("rst_bp_hit", 32'(bp_hit), 32'h0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_state_run", 32'(dbg_state), 32'd0);

    // Free run, then a load-use on rs
    rst = 1'b0;
    settle();
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("run_en", 32'(en), 32'h1F);
    hz(1'b1, 1'b1, 5'd1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    check("lu_rs_en", 32'(en), 32'h07);
    check("lu_rs_flush", 32'(fl), 32'h1);
    tick();
    hz(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    check("lu_rs_cnt", 32'(stall_cnt), 32'd1);
    check("lu_after_en", 32'(en), 32'h1F);

    hz(1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    check("lu_r0_en", 32'(en), 32'h1F);
    hz(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    check("no_load_en", 32'(en), 32'h1F);
    hz(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0);
    settle();
    check("lu_rt_en", 32'(en), 32'h07);
    tick();
    settle();
    check("lu_rt_cnt", 32'(stall_cnt), 32'd2);

    // Load-use coinciding with a taken branch: branch wins
    hz(1'b1, 1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1);
    settle();
    check("br_lu_en", 32'(en), 32'h1F);
    check("br_lu_flush", 32'(fl), 32'h3);
    tick();
    hz(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    check("br_lu_cnt", 32'(stall_cnt), 32'd2);

    // Halt and step 3
    debug_en = 1'b1;
    tick();
    settle();
    check("halt_state", 32'(dbg_state), 32'd1);
    check("halt_flag", 32'(dbg_halted), 32'd1);
    check("halt_en", 32'(en), 32'h00);
    step_count = 8'd3;
    debug_step = 1'b1;
    settle();
    check("halt_edge_en", 32'(en), 32'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("step3_state_%0d", i), 32'(dbg_state), 32'd2);
      check($sformatf("step3_en_%0d", i), 32'(en), 32'h1F);
    end
    tick();
    check("step3_done_halt", 32'(dbg_halted), 32'd1);
    check("step3_done_en", 32'(en), 32'h00);

    // step_count 0 runs one cycle
    debug_step = 1'b0;
    tick();
    step_count = 8'd0;
    debug_step = 1'b1;
    tick();
    check("step0_en", 32'(en), 32'h1F);
    tick();
    check("step0_halt", 32'(dbg_halted), 32'd1);

    // step 2 with a stall in the middle
    debug_step = 1'b0;
    tick();
    step_count = 8'd2;
    debug_step = 1'b1;
    tick();
    check("step2_a_en", 32'(en), 32'h1F);
    tick();
    hz(1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    check("step2_stall_en", 32'(en), 32'h07);
    check("step2_stall_state", 32'(dbg_state), 32'd2);
    tick();
    hz(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    check("step2_b_en", 32'(en), 32'h1F);
    tick();
    check("step2_halt", 32'(dbg_halted), 32'd1);
    check("step2_stall_cnt", 32'(stall_cnt), 32'd3);

    // Reset in the middle of a 5-step
    debug_step = 1'b0;
    tick();
    step_count = 8'd5;
    debug_step = 1'b1;
    tick();
    check("step5_en", 32'(en), 32'h1F);
    tick();
    rst = 1'b1;
    settle();
    check("step5_rst_cpu", 32'(cpu_rst), 32'd1);
    check("step5_rst_en", 32'(en), 32'h00);
    tick();
    rst = 1'b0;
    settle();
    check("post_rst_state", 32'(dbg_state), 32'd1);
    check("post_rst_en", 32'(en), 32'h00);
    check("post_rst_cnt", 32'(stall_cnt), 32'd0);
    tick();
    check("post_rst_noedge_state", 32'(dbg_state), 32'd1);
    check("post_rst_noedge_en", 32'(en), 32'h00);
    tick();
    check("post_rst_idle_en", 32'(en), 32'h00);
    debug_step = 1'b0;
    tick();
    debug_step = 1'b1;
    tick();
    check("new_edge_state", 32'(dbg_state), 32'd2);
    check("new_edge_en", 32'(en), 32'h1F);
    debug_en = 1'b0;
    tick();
    check("step_to_run", 32'(dbg_state), 32'd0);
    debug_step = 1'b0;

    // Breakpoints
    bp_addr = '0;
    bp_addr[ADDR_W-1:0] = 32'h40;
    bp_valid = 4'b0001;
    if_pc = 32'h3C;
    settle();
    check("bp_miss_hit", 32'(bp_hit), 32'h0);
    check("bp_miss_en", 32'(en), 32'h1F);
`ifdef PIPE_CTRL_BP_EN
    if_pc = 32'h40;
    debug_en = 1'b1;
    settle();
    check("bp_hit_pulse", 32'(bp_hit), 32'h1);
    check("bp_hit_if_en", 32'(if_en), 32'd0);
    tick();
    check("bp_halted", 32'(dbg_halted), 32'd1);
    check("bp_hit_cleared", 32'(bp_hit), 32'h0);
    step_count = 8'd1;
    debug_step = 1'b1;
    tick();
    check("bp_step_state", 32'(dbg_state), 32'd2);
    check("bp_step_hit", 32'(bp_hit), 32'h0);
    check("bp_step_if_en", 32'(if_en), 32'd1);
    tick();
    check("bp_step_halt", 32'(dbg_halted), 32'd1);
`else
    if_pc = 32'h40;
    settle();
    check("nobp_hit", 32'(bp_hit), 32'h0);
    check("nobp_if_en", 32'(if_en), 32'd1);
    tick();
    check("nobp_state", 32'(dbg_state), 32'd0);
    check("nobp_hit_next", 32'(bp_hit), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and breakpoint addresses.
REQ-002 Parameter NUM_BP, default 4, number of breakpoint slots.
REQ-003 Parameter STEP_W, default 8, width of step-count input and counter.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 debug_en  input  1  level; 1 requests halt, 0 requests free run.
REQ-007 debug_step  input  1  level; each rising edge (0->1 between two clk samples) is one step request.
REQ-008 step_count  input  STEP_W  cycles to run per step request; 0 treated as 1.
REQ-009 bp_addr  input  NUM_BP*ADDR_W  packed breakpoint addresses; slot i at [i*ADDR_W +: ADDR_W].
REQ-010 bp_valid  input  NUM_BP  per-slot enable.
REQ-011 if_pc  input  ADDR_W  PC of instruction in IF.
REQ-012 id_rs, id_rt  input  5 each  source registers of instruction in ID.
REQ-013 id_uses_rs, id_uses_rt  input  1 each  ID instruction reads rs / rt.
REQ-014 ex_mem_ren, ex_wb_wen  input  1 each  EX instruction is a load / writes back.
REQ-015 ex_wb_addr  input  5  destination register of EX instruction.
REQ-016 ex_branch_taken  input  1  EX resolved a taken branch/jump.
REQ-017 cpu_rst  output  1  pipeline reset.
REQ-018 if_en, id_en, ex_en, mem_en, wb_en  output  1 each  per-stage register enables.
REQ-019 id_flush, ex_flush  output  1 each  load bubble into IF/ID or ID/EX register.
REQ-020 dbg_state  output  2  FSM state code; dbg_halted  output  1  state==HALT.
REQ-021 bp_hit  output  NUM_BP  one-cycle per-slot hit pulse; stall_cnt  output  16  load-use stall counter.

Function
REQ-022 FSM states RUN=0, HALT=1, STEP=2; code 3 unreachable, recovers to HALT.
REQ-023 RUN->HALT when debug_en=1 or any breakpoint hit; HALT->RUN when debug_en=0; HALT->STEP on step edge, loading counter with max(step_count,1).
REQ-024 STEP: counter decrements on each advancing (non-stalled) cycle; advancing cycle with counter==1 -> HALT; debug_en=0 in STEP -> RUN.
REQ-025 Breakpoint hit: RUN, bp_valid[i]=1, if_pc==slot i; halts before the IF instruction advances (if_en=0 that cycle); bp_hit[i] pulses exactly one cycle.
REQ-026 Breakpoints ignored in STEP and HALT, so stepping off a breakpoint proceeds.
REQ-027 Load-use hazard = ex_mem_ren & ex_wb_wen & ex_wb_addr!=0 & ((id_uses_rs & rs==ex_wb_addr) | (id_uses_rt & rt==ex_wb_addr)).
REQ-028 Hazard, not halted: if_en=id_en=0, ex_flush=1, ex/mem/wb_en=1; not an advancing cycle.
REQ-029 ex_branch_taken, not halted: id_flush=1, ex_flush=1, all enables 1; overrides load-use (hazard not stalled, not counted).
REQ-030 HALT: all enables 0, both flushes 0; step edge in HALT takes effect next cycle (registered).
REQ-031 stall_cnt increments per stalled cycle in RUN/STEP, saturates at 16'hFFFF.
REQ-032 Outputs other than registered state are combinational from state and current inputs; zero-latency gating.

Reset
REQ-033 rst=1: cpu_rst=1, state=HALT if debug_en else RUN, counter=0, stall_cnt=0, step-edge history=0, bp_hit=0, all enables 0, flushes 0.
REQ-034 Reset mid-STEP discards remaining count; no step edge detected in the cycle rst deasserts.

Configuration
REQ-035 Macro PIPE_CTRL_BP_EN: defined -> breakpoint logic per REQ-025/026; undefined -> no comparators, bp_hit tied 0, bp_addr/bp_valid ignored, ports retained.

Structure
REQ-036 Shared package holds FSM state codes (RUN/HALT/STEP) and stall_cnt width constant.
REQ-037 Sub-module pipe_hazard (combinational load-use/branch detect) is instantiated once.

Verification
REQ-038 rst, debug_en=0, then lw $1 in EX with ID add using $1 -> one cycle if_en=0, ex_flush=1, stall_cnt=1.
REQ-039 debug_en=1, step_count=3, one step edge, no hazards -> exactly 3 cycles of all enables=1, then HALT.
REQ-040 step_count=0 -> exactly 1 advancing cycle; with a load-use stall mid-step (count 2) -> 3 enabled cycles total.
REQ-041 BP_EN, bp_valid=0001, bp_addr slot0=0x40, if_pc reaches 0x40 -> if_en=0 same cycle, bp_hit=0001 one cycle, HALT; step edge -> advances past 0x40.
REQ-042 Load-use hazard and ex_branch_taken same cycle -> id_flush=ex_flush=1, if_en=1, stall_cnt unchanged.
REQ-043 rst asserted in STEP with count 5 -> HALT (debug_en=1), counter 0, no enables until a new step edge.
